// File: rtl/smp_seq_ctrl_if.sv
// ============================================================================
// Module   : smp_seq_ctrl_if
// Purpose  : Handshake and status bundle between trigger logic and the
//            sample-window sequencer (smp_seq_ctrl).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface smp_seq_ctrl_if #(
  parameter int WIDTH     = 4,
  parameter int DLY_WIDTH = 8
);
  logic                 trig;
  logic [DLY_WIDTH-1:0] dly;
  logic [WIDTH-1:0]     nsmp;
  logic                 hold;
  logic                 abort;
  logic                 clr_ovf;
  logic                 ce;
  logic                 clr;
  logic [WIDTH-1:0]     addr;
  logic                 busy;
  logic                 done;
  logic                 ovf;

  // Trigger-side view: drives requests, observes status.
  modport master (
    output trig, dly, nsmp, hold, abort, clr_ovf,
    input  ce, clr, addr, busy, done, ovf
  );

  // Sequencer view.
  modport slave (
    input  trig, dly, nsmp, hold, abort, clr_ovf,
    output ce, clr, addr, busy, done, ovf
  );
endinterface

`default_nettype wire

// File: rtl/smp_seq_ctrl.sv
// ============================================================================
// Module   : smp_seq_ctrl
// Purpose  : Sample-window sequencer for the CFEB sample-address counter.
//            Trigger -> clear counter -> programmable delay -> NSMP counted
//            samples, with hold, abort, done pulse and lost-trigger flag.
// Options  : CFEB_SEQ_TMR_EN - triplicates state, delay counter, remaining
//            counter and ADDR with a bitwise majority vote (self-scrubbing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module smp_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DLY_WIDTH = 8
) (
  input wire logic      clk,
  input wire logic      rst,
  smp_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_DELAY = 3'd2,
    S_RUN   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

`ifdef CFEB_SEQ_TMR_EN
  localparam int COPIES = 3;
`else
  localparam int COPIES = 1;
`endif

  // Register copies; the state copies are plain vectors so that a corrupted
  // copy can hold any bit pattern, the vote restores a legal encoding.
  (* keep = "true" *) logic [2:0]           state_q [COPIES];
  (* keep = "true" *) logic [DLY_WIDTH-1:0] dly_q   [COPIES];
  (* keep = "true" *) logic [WIDTH-1:0]     rem_q   [COPIES];
  (* keep = "true" *) logic [WIDTH-1:0]     addr_q  [COPIES];
  logic                                     ovf_q;

  // Voted (or single-copy) current values that all logic decodes from.
  state_t               state_v;
  logic [DLY_WIDTH-1:0] dly_v;
  logic [WIDTH-1:0]     rem_v;
  logic [WIDTH-1:0]     addr_v;

`ifdef CFEB_SEQ_TMR_EN
  // Bitwise 2-of-3 majority of each triplicated register.
  always_comb begin
    state_v = state_t'((state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) |
                       (state_q[1] & state_q[2]));
    dly_v   = (dly_q[0] & dly_q[1]) | (dly_q[0] & dly_q[2]) | (dly_q[1] & dly_q[2]);
    rem_v   = (rem_q[0] & rem_q[1]) | (rem_q[0] & rem_q[2]) | (rem_q[1] & rem_q[2]);
    addr_v  = (addr_q[0] & addr_q[1]) | (addr_q[0] & addr_q[2]) |
              (addr_q[1] & addr_q[2]);
  end
`else
  // Single copy: pass the registers straight through.
  always_comb begin
    state_v = state_t'(state_q[0]);
    dly_v   = dly_q[0];
    rem_v   = rem_q[0];
    addr_v  = addr_q[0];
  end
`endif

  // Window FSM; every copy is rewritten from the voted value each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      for (int i = 0; i < COPIES; i++) begin
        state_q[i] <= S_IDLE;
        dly_q[i]   <= '0;
        rem_q[i]   <= '0;
        addr_q[i]  <= '0;
      end
    end else begin
      // A trigger outside IDLE is lost; setting beats a simultaneous clear.
      if (bus.trig && (state_v != S_IDLE)) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end

      for (int i = 0; i < COPIES; i++) begin
        state_q[i] <= state_v;
        dly_q[i]   <= dly_v;
        rem_q[i]   <= rem_v;
        addr_q[i]  <= addr_v;

        if (bus.abort) begin
          // Abort returns to IDLE with ADDR held; in IDLE it masks TRIG.
          state_q[i] <= S_IDLE;
        end else begin
          case (state_v)
            S_IDLE: begin
              if (bus.trig) begin
                state_q[i] <= S_ARM;
                dly_q[i]   <= bus.dly;
                rem_q[i]   <= bus.nsmp;
              end
            end
            S_ARM: begin
              addr_q[i]  <= '0;
              state_q[i] <= (dly_v != '0) ? S_DELAY : S_RUN;
            end
            S_DELAY: begin
              dly_q[i] <= dly_v - 1'b1;
              if (dly_v == DLY_WIDTH'(1)) begin
                state_q[i] <= S_RUN;
              end
            end
            S_RUN: begin
              // Remaining count of 0 wraps, giving the full 2^WIDTH range.
              if (!bus.hold) begin
                addr_q[i] <= addr_v + 1'b1;
                rem_q[i]  <= rem_v - 1'b1;
                if (rem_v == WIDTH'(1)) begin
                  state_q[i] <= S_FIN;
                end
              end
            end
            S_FIN: begin
              state_q[i] <= S_IDLE;
            end
            default: begin
              state_q[i] <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  // Output decode from the voted state; CE follows HOLD combinationally.
  assign bus.ce   = (state_v == S_RUN) && !bus.hold;
  assign bus.clr  = (state_v == S_ARM);
  assign bus.done = (state_v == S_FIN);
  assign bus.busy = (state_v != S_IDLE);
  assign bus.addr = addr_v;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire

// File: doc/smp_seq_ctrl.md
# smp_seq_ctrl

Sample-window sequencer for the CFEB sample-address counter. On a trigger it clears the counter, waits a programmable delay, then enables counting for a programmed number of samples, with pause and abort. It also reports completion and lost triggers. It sits between trigger logic and the TMR sample-address counter, and drives that counter's CE and clear inputs.

## Interface
Parameters:
- Width, 4: sample-address width; also the width of NSMP.
- DlyWidth, 8: width of the delay input.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- TRIG  in  1  start request, level-sampled at each edge.
- DLY  in  DlyWidth  delay cycles before sampling; latched at trigger acceptance.
- NSMP  in  Width  number of samples; latched at acceptance; 0 means 2^Width.
- HOLD  in  1  pauses counting during RUN.
- ABORT  in  1  terminates the window early.
- CLR_OVF  in  1  clears OVF.
- CE  out  1  count enable to the address counter.
- CLR  out  1  one-cycle clear to the address counter.
- ADDR  out  Width  shadow of the sample index.
- BUSY  out  1  window in progress.
- DONE  out  1  one-cycle completion pulse.
- OVF  out  1  sticky flag: a trigger was lost.

## Operation
- States: IDLE, ARM, DELAY, RUN, FIN.
- IDLE:
  - TRIG=1 → ARM.
  - At the same edge, latch DLY into the delay counter and NSMP into the remaining-sample counter.
- ARM:
  - Lasts one cycle with CLR=1.
  - At its closing edge ADDR←0.
  - Next state is DELAY if the latched DLY≠0, else RUN.
- DELAY:
  - Lasts exactly DLY cycles; the counter decrements each cycle.
  - Moves to RUN at the edge where the counter is 1.
  - HOLD has no effect in DELAY.
- RUN:
  - CE = ~HOLD, combinational from the HOLD input.
  - On each edge with CE=1: ADDR increments modulo 2^Width and the remaining count decrements.
  - An edge with CE=1 and remaining=1 → FIN.
  - Latched NSMP=0 wraps through the full range, giving 2^Width CE cycles.
- FIN: lasts one cycle with DONE=1, then → IDLE.
- Output decode:
  - BUSY=1 in every state except IDLE.
  - CE=0 in every state except RUN.
  - ADDR holds its value outside ARM and RUN CE cycles.
- TRIG outside IDLE is ignored and sets OVF.
  - This includes TRIG in FIN.
  - OVF clears only on RST or CLR_OVF.
  - If CLR_OVF and a lost TRIG occur in the same cycle, OVF is set (set wins).
- ABORT in any state other than IDLE → IDLE at the next edge.
  - No DONE pulse is produced and ADDR holds.
  - ABORT in IDLE blocks a simultaneous TRIG, which is not accepted and does not set OVF.
- Priority: RST > ABORT > normal transitions.

## Timing
- Reset values: all outputs 0; state IDLE; internal counters 0.
- RST asserted mid-window: at the next edge the block is in IDLE with all outputs 0. No DONE pulse.
- TRIG sampled at edge E0:
  - CLR=1 during the cycle E0→E1.
  - First CE cycle begins at E1+DLY.
- Without HOLD, the window is 1+DLY+NSMP cycles of BUSY, followed by one DONE cycle.
- Each HOLD cycle in RUN adds exactly one cycle to the window.
- DONE is high for the single cycle after the last CE cycle. BUSY stays 1 during that cycle and falls with DONE.
- The earliest next trigger acceptance is in the cycle after FIN, i.e. IDLE, since TRIG in FIN is lost.

## Configuration
- Macro: CFEB_SEQ_TMR_EN.
- Defined:
  - The state register, delay counter, remaining counter and ADDR are triplicated.
  - Each copy's next value is computed from the bitwise majority vote of the three copies, and all three copies are rewritten every cycle, so a single upset is scrubbed in one cycle.
  - Outputs decode from the voted values.
  - Synthesis must preserve the three copies and the vote.
- Undefined: single copy of each register and no voter.
- Port-level behaviour is identical in both builds.

## Test plan
- Basic window: RST, then DLY=3, NSMP=5, one-cycle TRIG.
  - Required: CLR high 1 cycle, 3 DELAY cycles, CE high 5 consecutive cycles, ADDR 0→5, DONE one cycle, BUSY high 10 cycles.
- Zero delay and full range: DLY=0, NSMP=0, Width=4.
  - Required: CE starts 1 cycle after the CLR cycle and lasts 16 cycles; ADDR wraps to 0; DONE after the 16th CE cycle.
- HOLD: DLY=0, NSMP=4; HOLD high for 2 cycles after the 2nd CE cycle.
  - Required: CE low for those 2 cycles, ADDR holds at 2, total 4 CE cycles, DONE 2 cycles later than without HOLD.
- Abort and lost trigger:
  - TRIG during RUN → OVF=1 and the window is unaffected.
  - Then ABORT mid-RUN → IDLE next cycle, no DONE, ADDR holds.
  - CLR_OVF → OVF=0.
  - RST mid-DELAY → all outputs 0 at the next edge.
- TMR scrub, with CFEB_SEQ_TMR_EN defined: force one copy of the state register to a wrong value for one cycle during RUN.
  - Required: no change on CE, ADDR or DONE, and the copies agree again one cycle later.
